// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI master among NREQ requesters.
// Launches one transfer at a time, tracks completion on m_ss, and aborts stalled transfers.
module spi_txn_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] req_data,
    input  logic [NREQ*2-1:0]  req_mode,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    done,
    output logic               err,
    output logic [DW-1:0]      rdata,
    output logic               busy,
    output logic               m_start,
    output logic [DW-1:0]      m_data,
    output logic [1:0]         m_mode,
    input  logic               m_ss,
    input  logic [DW-1:0]      m_rdata
);

    localparam int unsigned IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned WDW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        WAIT_LO = 3'd2,
        WAIT_HI = 3'd3,
        FINISH  = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [IW-1:0]   ptr, ptr_nxt;
    logic [IW-1:0]   winner, winner_nxt;
    logic [WDW-1:0]  wd, wd_nxt;
    logic            timed_out, timed_out_nxt;

    logic [NREQ-1:0] gnt_nxt, done_nxt;
    logic            err_nxt, busy_nxt, m_start_nxt;
    logic [DW-1:0]   rdata_nxt, m_data_nxt;
    logic [1:0]      m_mode_nxt;

    logic [IW-1:0]   pick_c;
    logic            pick_valid_c;
    logic            wd_expired_c;
    int unsigned     idx;

    // First set request at or after ptr, searching upward with wrap-around.
    always_comb begin
        pick_c       = '0;
        pick_valid_c = 1'b0;
        idx          = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!pick_valid_c && req[IW'(idx)]) begin
                pick_valid_c = 1'b1;
                pick_c       = IW'(idx);
            end
        end
    end

    assign wd_expired_c = (wd == WDW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; the watchdog overrides a pending m_ss transition.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pick_valid_c) state_nxt = LAUNCH;
            LAUNCH:  state_nxt = WAIT_LO;
            WAIT_LO: begin
                if (wd_expired_c)  state_nxt = FINISH;
                else if (!m_ss)    state_nxt = WAIT_HI;
            end
            WAIT_HI: begin
                if (wd_expired_c || m_ss) state_nxt = FINISH;
            end
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered outputs and datapath.
    always_comb begin
        gnt_nxt       = gnt;
        done_nxt      = '0;
        err_nxt       = 1'b0;
        rdata_nxt     = rdata;
        busy_nxt      = (state_nxt != IDLE);
        m_start_nxt   = 1'b0;
        m_data_nxt    = m_data;
        m_mode_nxt    = m_mode;
        ptr_nxt       = ptr;
        winner_nxt    = winner;
        wd_nxt        = wd;
        timed_out_nxt = timed_out;
        case (state)
            IDLE: begin
                if (pick_valid_c) begin
                    winner_nxt  = pick_c;
                    gnt_nxt     = NREQ'(1) << pick_c;
                    m_start_nxt = 1'b1;
                    m_data_nxt  = req_data[pick_c*DW +: DW];
                    m_mode_nxt  = req_mode[pick_c*2 +: 2];
                end
            end
            LAUNCH: begin
                wd_nxt        = '0;
                timed_out_nxt = 1'b0;
            end
            WAIT_LO, WAIT_HI: begin
                if (wd_expired_c) timed_out_nxt = 1'b1;
                else              wd_nxt        = wd + WDW'(1);
            end
            FINISH: begin
                rdata_nxt = m_rdata;
                done_nxt  = NREQ'(1) << winner;
                err_nxt   = timed_out;
                gnt_nxt   = '0;
                ptr_nxt   = (winner == IW'(NREQ - 1)) ? '0 : winner + IW'(1);
            end
            default: ;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt       <= '0;
            done      <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            busy      <= 1'b0;
            m_start   <= 1'b0;
            m_data    <= '0;
            m_mode    <= '0;
            ptr       <= '0;
            winner    <= '0;
            wd        <= '0;
            timed_out <= 1'b0;
        end else begin
            gnt       <= gnt_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            rdata     <= rdata_nxt;
            busy      <= busy_nxt;
            m_start   <= m_start_nxt;
            m_data    <= m_data_nxt;
            m_mode    <= m_mode_nxt;
            ptr       <= ptr_nxt;
            winner    <= winner_nxt;
            wd        <= wd_nxt;
            timed_out <= timed_out_nxt;
        end
    end

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Scoreboard bench for spi_txn_arbiter with a behavioural SPI master stand-in.
// Launch and completion expectations are queued by the stimulus and checked by a monitor.
module tb_spi_txn_arbiter;

    localparam int unsigned NREQ    = 4;
    localparam int unsigned DW      = 8;
    localparam int unsigned TIMEOUT = 16;
    localparam int NORMAL_LAT  = 9;   // m_start cycle to done cycle with the stand-in master
    localparam int TIMEOUT_LAT = 18;  // LAUNCH + 16 watchdog cycles + FINISH

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] req_data = '0;
    logic [NREQ*2-1:0]  req_mode = '0;
    logic [NREQ-1:0]    gnt, done;
    logic               err, busy, m_start;
    logic [DW-1:0]      rdata, m_data;
    logic [1:0]         m_mode;
    logic               m_ss = 1'b1;
    logic [DW-1:0]      m_rdata = '0;

    logic               stuck = 1'b0;
    logic [DW-1:0]      slave_xor = '0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [NREQ-1:0] oh;
        logic [DW-1:0]   d;
        logic [1:0]      mo;
        logic [DW-1:0]   rd;
        logic            e;
    } exp_t;

    exp_t lq[$];
    exp_t dq[$];

    spi_txn_arbiter #(.NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_mode(req_mode),
        .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
        .m_start(m_start), .m_data(m_data), .m_mode(m_mode),
        .m_ss(m_ss), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s", name);
    endtask

    task automatic push(input logic [NREQ-1:0] oh, input logic [DW-1:0] d,
                        input logic [1:0] mo, input logic [DW-1:0] rd, input logic e);
        exp_t x;
        x = '{oh: oh, d: d, mo: mo, rd: rd, e: e};
        lq.push_back(x);
        dq.push_back(x);
    endtask

    task automatic wait_dones(input int n, input bit hold, input int budget);
        int got = 0;
        int t = 0;
        while (got < n && t < budget) begin
            @(negedge clk);
            t++;
            if (done != '0) begin
                got++;
                if (!hold) req = req & ~done;
                if (got == n) req = '0;
            end
        end
        if (got < n) begin
            req = '0;
            flag("done_timeout");
        end
    endtask

    task automatic wait_start(input int budget);
        int t = 0;
        while (!m_start && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (!m_start) flag("start_timeout");
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"},     32'(gnt),     32'h0);
        chk({tag, "_done"},    32'(done),    32'h0);
        chk({tag, "_err"},     32'(err),     32'h0);
        chk({tag, "_rdata"},   32'(rdata),   32'h0);
        chk({tag, "_busy"},    32'(busy),    32'h0);
        chk({tag, "_m_start"}, 32'(m_start), 32'h0);
        chk({tag, "_m_data"},  32'(m_data),  32'h0);
        chk({tag, "_m_mode"},  32'(m_mode),  32'h0);
    endtask

    // Behavioural SPI master: SS low one cycle after start, high six cycles later.
    initial begin
        forever begin
            @(negedge clk);
            if (m_start && rst_n) begin
                if (stuck) begin
                    m_rdata = 8'hE7;
                end else begin
                    @(negedge clk);
                    m_ss    = 1'b0;
                    m_rdata = 8'h00;
                    repeat (6) @(negedge clk);
                    m_rdata = m_data ^ slave_xor;
                    m_ss    = 1'b1;
                end
            end
        end
    end

    // Monitor: checks launches and completions against the scoreboard queues.
    initial begin
        int cyc = 0;
        int start_cyc = 0;
        logic [DW-1:0] cur_d = '0;
        logic [1:0]    cur_m = '0;
        exp_t x;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) continue;
            if (m_start) begin
                if (lq.size() == 0) begin
                    flag("unexpected_start");
                end else begin
                    x = lq.pop_front();
                    chk("start_m_data", 32'(m_data), 32'(x.d));
                    chk("start_m_mode", 32'(m_mode), 32'(x.mo));
                    chk("start_gnt",    32'(gnt),    32'(x.oh));
                    chk("start_busy",   32'(busy),   32'h1);
                end
                start_cyc = cyc;
                cur_d = m_data;
                cur_m = m_mode;
            end else if (gnt != '0) begin
                chk("hold_m_data", 32'(m_data), 32'(cur_d));
                chk("hold_m_mode", 32'(m_mode), 32'(cur_m));
            end
            if (done != '0) begin
                if (dq.size() == 0) begin
                    flag("unexpected_done");
                end else begin
                    x = dq.pop_front();
                    chk("done_onehot", 32'(done),  32'(x.oh));
                    chk("done_rdata",  32'(rdata), 32'(x.rd));
                    chk("done_err",    32'(err),   32'(x.e));
                    chk("done_gnt",    32'(gnt),   32'h0);
                    chk("done_busy",   32'(busy),  32'h0);
                    chk("done_latency", 32'(cyc - start_cyc),
                        32'(x.e ? TIMEOUT_LAT : NORMAL_LAT));
                end
            end else if (err) begin
                flag("err_without_done");
            end
        end
    end

    initial begin
        int seen;
        // Reset values
        repeat (2) @(negedge clk);
        chk_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals("post_rst");

        // Single request from requester 1
        slave_xor = 8'h99;
        req_data[1*DW +: DW] = 8'hA5;
        req_mode[1*2 +: 2]   = 2'd0;
        push(4'b0010, 8'hA5, 2'd0, 8'h3C, 1'b0);
        req = 4'b0010;
        @(negedge clk);
        chk("req_to_gnt",   32'(gnt),     32'h2);
        chk("req_to_start", 32'(m_start), 32'h1);
        chk("req_to_busy",  32'(busy),    32'h1);
        wait_dones(1, 1'b0, 40);
        @(negedge clk);
        chk("idle_m_data_held", 32'(m_data), 32'hA5);
        chk("idle_busy",        32'(busy),   32'h0);
        chk("idle_m_start",     32'(m_start), 32'h0);

        // Contention with all requests held, starting from ptr=0
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        slave_xor = 8'h5A;
        req_data = {8'h43, 8'h32, 8'h21, 8'h10};
        req_mode = {2'd3, 2'd2, 2'd1, 2'd0};
        push(4'b0001, 8'h10, 2'd0, 8'h10 ^ 8'h5A, 1'b0);
        push(4'b0010, 8'h21, 2'd1, 8'h21 ^ 8'h5A, 1'b0);
        push(4'b0100, 8'h32, 2'd2, 8'h32 ^ 8'h5A, 1'b0);
        push(4'b1000, 8'h43, 2'd3, 8'h43 ^ 8'h5A, 1'b0);
        push(4'b0001, 8'h10, 2'd0, 8'h10 ^ 8'h5A, 1'b0);
        req = 4'b1111;
        wait_dones(5, 1'b1, 100);

        // Fairness after wrap: move ptr to 3, then requesters 3 and 0 compete
        push(4'b0100, 8'h32, 2'd2, 8'h32 ^ 8'h5A, 1'b0);
        req = 4'b0100;
        wait_dones(1, 1'b0, 40);
        push(4'b1000, 8'h43, 2'd3, 8'h43 ^ 8'h5A, 1'b0);
        push(4'b0001, 8'h10, 2'd0, 8'h10 ^ 8'h5A, 1'b0);
        req = 4'b1001;
        wait_dones(2, 1'b0, 60);

        // Stability: requester 0 changes inputs and drops req mid-transfer
        req_data[0 +: DW] = 8'h11;
        req_mode[0 +: 2]  = 2'd1;
        push(4'b0001, 8'h11, 2'd1, 8'h11 ^ 8'h5A, 1'b0);
        req = 4'b0001;
        wait_start(10);
        @(negedge clk);
        req_data[0 +: DW] = 8'hFF;
        req_mode[0 +: 2]  = 2'd2;
        req = 4'b0000;
        wait_dones(1, 1'b0, 40);

        // Watchdog abort with m_ss stuck high
        stuck = 1'b1;
        req_data[1*DW +: DW] = 8'hC3;
        req_mode[1*2 +: 2]   = 2'd0;
        push(4'b0010, 8'hC3, 2'd0, 8'hE7, 1'b1);
        req = 4'b0010;
        wait_dones(1, 1'b0, 60);
        @(negedge clk);
        chk("timeout_gnt_clear", 32'(gnt),  32'h0);
        chk("timeout_busy",      32'(busy), 32'h0);
        stuck = 1'b0;

        // Reset during WAIT_HI
        req_data[2*DW +: DW] = 8'h5D;
        req_mode[2*2 +: 2]   = 2'd3;
        push(4'b0100, 8'h5D, 2'd3, 8'h5D ^ 8'h5A, 1'b0);
        req = 4'b0100;
        wait_start(10);
        repeat (3) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        req = '0;
        #1;
        chk_reset_vals("mid_rst");
        lq.delete();
        dq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done != '0) seen++;
        end
        chk("no_done_after_rst", 32'(seen), 32'h0);
        chk("rst_idle_busy",     32'(busy), 32'h0);

        chk("lq_empty", 32'(lq.size()), 32'h0);
        chk("dq_empty", 32'(dq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
